// File: rtl/sap1_control_sequencer.sv
// SAP-1 microcode sequencer: T-state counter, opcode decode and control-word generation.
// Control outputs are pure decodes of the current T-state, opcode, flags and halt latch.
module sap1_control_sequencer #(
    parameter bit EXT_ISA = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       carry_flag,
    input  logic       zero_flag,
    output logic [2:0] t_state,
    output logic       instr_done,
    output logic       halted,
    output logic       hlt,
    output logic       mi,
    output logic       ri,
    output logic       ro,
    output logic       ii,
    output logic       io,
    output logic       ai,
    output logic       ao,
    output logic       eo,
    output logic       su,
    output logic       fi,
    output logic       bi,
    output logic       oi,
    output logic       pc_inc,
    output logic       co,
    output logic       pc_load
);

    localparam logic [3:0] OpNop = 4'h0;
    localparam logic [3:0] OpLda = 4'h1;
    localparam logic [3:0] OpAdd = 4'h2;
    localparam logic [3:0] OpSub = 4'h3;
    localparam logic [3:0] OpSta = 4'h4;
    localparam logic [3:0] OpLdi = 4'h5;
    localparam logic [3:0] OpJmp = 4'h6;
    localparam logic [3:0] OpJc  = 4'h7;
    localparam logic [3:0] OpJz  = 4'h8;
    localparam logic [3:0] OpOut = 4'he;
    localparam logic [3:0] OpHlt = 4'hf;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    logic [2:0] t_state_q, t_state_d;
    logic       halt_q, halt_d;
    logic [3:0] op_eff;
    logic [2:0] last_t;

    // Extended opcodes collapse to NOP when the classic instruction set is selected.
    always_comb begin
        op_eff = opcode;
        if (!EXT_ISA && (opcode inside {OpSta, OpLdi, OpJmp, OpJc, OpJz})) begin
            op_eff = OpNop;
        end
    end

    always_comb begin
        case (op_eff)
            OpLda, OpSta: last_t = T3;
            OpAdd, OpSub: last_t = T4;
            default:      last_t = T2;
        endcase
    end

    always_comb begin
        instr_done = 1'b0;
        hlt        = 1'b0;
        mi         = 1'b0;
        ri         = 1'b0;
        ro         = 1'b0;
        ii         = 1'b0;
        io         = 1'b0;
        ai         = 1'b0;
        ao         = 1'b0;
        eo         = 1'b0;
        su         = 1'b0;
        fi         = 1'b0;
        bi         = 1'b0;
        oi         = 1'b0;
        pc_inc     = 1'b0;
        co         = 1'b0;
        pc_load    = 1'b0;
        if (!reset && halt_q) begin
            hlt = 1'b1;
        end else if (!reset) begin
            case (t_state_q)
                T0: begin
                    co = 1'b1;
                    mi = 1'b1;
                end
                T1: begin
                    ro     = 1'b1;
                    ii     = 1'b1;
                    pc_inc = 1'b1;
                end
                T2, T3, T4: begin
                    instr_done = (t_state_q == last_t);
                    case (op_eff)
                        OpLda: begin
                            if (t_state_q == T2) begin
                                io = 1'b1;
                                mi = 1'b1;
                            end else if (t_state_q == T3) begin
                                ro = 1'b1;
                                ai = 1'b1;
                            end
                        end
                        OpAdd, OpSub: begin
                            if (t_state_q == T2) begin
                                io = 1'b1;
                                mi = 1'b1;
                            end else if (t_state_q == T3) begin
                                ro = 1'b1;
                                bi = 1'b1;
                            end else begin
                                eo = 1'b1;
                                ai = 1'b1;
                                fi = 1'b1;
                                su = (op_eff == OpSub);
                            end
                        end
                        OpSta: begin
                            if (t_state_q == T2) begin
                                io = 1'b1;
                                mi = 1'b1;
                            end else if (t_state_q == T3) begin
                                ao = 1'b1;
                                ri = 1'b1;
                            end
                        end
                        OpLdi: begin
                            if (t_state_q == T2) begin
                                io = 1'b1;
                                ai = 1'b1;
                            end
                        end
                        OpJmp: begin
                            if (t_state_q == T2) begin
                                io      = 1'b1;
                                pc_load = 1'b1;
                            end
                        end
                        // Flags only matter in the T2 of a conditional jump.
                        OpJc: begin
                            if (t_state_q == T2) begin
                                io      = 1'b1;
                                pc_load = carry_flag;
                            end
                        end
                        OpJz: begin
                            if (t_state_q == T2) begin
                                io      = 1'b1;
                                pc_load = zero_flag;
                            end
                        end
                        OpOut: begin
                            if (t_state_q == T2) begin
                                ao = 1'b1;
                                oi = 1'b1;
                            end
                        end
                        OpHlt: begin
                            if (t_state_q == T2) begin
                                hlt = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Wrapping on t_state_q >= last_t also recovers from illegal counts 5..7.
    always_comb begin
        t_state_d = t_state_q;
        halt_d    = halt_q;
        if (halt_q) begin
            t_state_d = T0;
        end else begin
            if (t_state_q >= last_t) begin
                t_state_d = T0;
            end else begin
                t_state_d = t_state_q + 3'd1;
            end
            if (hlt) begin
                halt_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            t_state_q <= T0;
            halt_q    <= 1'b0;
        end else begin
            t_state_q <= t_state_d;
            halt_q    <= halt_d;
        end
    end

    assign t_state = t_state_q;
    assign halted  = halt_q;

endmodule

// File: tb/tb_sap1_control_sequencer.sv
// Bench for sap1_control_sequencer: per-cycle expected control words are queued with the
// stimulus and compared as each cycle is sampled; a monitor checks bus-driver exclusivity.
module tb_sap1_control_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic       carry_flag;
    logic       zero_flag;

    logic [2:0] t_state_a, t_state_b;
    logic instr_done_a, halted_a, hlt_a, mi_a, ri_a, ro_a, ii_a, io_a, ai_a, ao_a, eo_a;
    logic su_a, fi_a, bi_a, oi_a, pc_inc_a, co_a, pc_load_a;
    logic instr_done_b, halted_b, hlt_b, mi_b, ri_b, ro_b, ii_b, io_b, ai_b, ao_b, eo_b;
    logic su_b, fi_b, bi_b, oi_b, pc_inc_b, co_b, pc_load_b;

    always #5 clk = ~clk;

    sap1_control_sequencer #(.EXT_ISA(1'b1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .carry_flag(carry_flag),
        .zero_flag(zero_flag), .t_state(t_state_a), .instr_done(instr_done_a),
        .halted(halted_a), .hlt(hlt_a), .mi(mi_a), .ri(ri_a), .ro(ro_a), .ii(ii_a),
        .io(io_a), .ai(ai_a), .ao(ao_a), .eo(eo_a), .su(su_a), .fi(fi_a), .bi(bi_a),
        .oi(oi_a), .pc_inc(pc_inc_a), .co(co_a), .pc_load(pc_load_a)
    );

    sap1_control_sequencer #(.EXT_ISA(1'b0)) dut_classic (
        .clk(clk), .reset(reset), .opcode(opcode), .carry_flag(carry_flag),
        .zero_flag(zero_flag), .t_state(t_state_b), .instr_done(instr_done_b),
        .halted(halted_b), .hlt(hlt_b), .mi(mi_b), .ri(ri_b), .ro(ro_b), .ii(ii_b),
        .io(io_b), .ai(ai_b), .ao(ao_b), .eo(eo_b), .su(su_b), .fi(fi_b), .bi(bi_b),
        .oi(oi_b), .pc_inc(pc_inc_b), .co(co_b), .pc_load(pc_load_b)
    );

    // Word layout: t_state[20:18] done halted hlt mi ri ro ii io ai ao eo su fi bi oi pcinc co pcl
    logic [20:0] w_a, w_b;
    assign w_a = {t_state_a, instr_done_a, halted_a, hlt_a, mi_a, ri_a, ro_a, ii_a, io_a,
                  ai_a, ao_a, eo_a, su_a, fi_a, bi_a, oi_a, pc_inc_a, co_a, pc_load_a};
    assign w_b = {t_state_b, instr_done_b, halted_b, hlt_b, mi_b, ri_b, ro_b, ii_b, io_b,
                  ai_b, ao_b, eo_b, su_b, fi_b, bi_b, oi_b, pc_inc_b, co_b, pc_load_b};

    localparam logic [20:0] DONE = 21'(1) << 17;
    localparam logic [20:0] HLTD = 21'(1) << 16;
    localparam logic [20:0] HLT  = 21'(1) << 15;
    localparam logic [20:0] MI   = 21'(1) << 14;
    localparam logic [20:0] RI   = 21'(1) << 13;
    localparam logic [20:0] RO   = 21'(1) << 12;
    localparam logic [20:0] II   = 21'(1) << 11;
    localparam logic [20:0] IO   = 21'(1) << 10;
    localparam logic [20:0] AI   = 21'(1) << 9;
    localparam logic [20:0] AO   = 21'(1) << 8;
    localparam logic [20:0] EO   = 21'(1) << 7;
    localparam logic [20:0] SU   = 21'(1) << 6;
    localparam logic [20:0] FI   = 21'(1) << 5;
    localparam logic [20:0] BI   = 21'(1) << 4;
    localparam logic [20:0] OI   = 21'(1) << 3;
    localparam logic [20:0] PCI  = 21'(1) << 2;
    localparam logic [20:0] CO   = 21'(1) << 1;
    localparam logic [20:0] PCL  = 21'(1);

    function automatic logic [20:0] ts(input int n);
        return 21'(n) << 18;
    endfunction

    // sel: 0 = check EXT_ISA=1 instance, 1 = check classic instance, 2 = no check
    typedef struct {
        logic [3:0]  op;
        logic        c;
        logic        z;
        logic        rst;
        int          sel;
        logic [20:0] exp;
    } step_t;

    step_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    running  = 1'b0;

    task automatic push(input logic [3:0] op, input logic c, input logic z, input logic rst,
                        input int sel, input logic [20:0] exp);
        step_t s;
        s.op = op; s.c = c; s.z = z; s.rst = rst; s.sel = sel; s.exp = exp;
        sb.push_back(s);
    endtask

    task automatic push_fetch(input logic [3:0] op, input logic c, input logic z,
                              input int sel);
        push(op, c, z, 1'b0, sel, ts(0) | CO | MI);
        push(op, c, z, 1'b0, sel, ts(1) | RO | II | PCI);
    endtask

    // Bus-driver exclusivity on both instances, sampled mid-cycle.
    always @(negedge clk) begin
        if (running) begin
            int na, nb;
            na = int'(co_a) + int'(ro_a) + int'(io_a) + int'(ao_a) + int'(eo_a);
            nb = int'(co_b) + int'(ro_b) + int'(io_b) + int'(ao_b) + int'(eo_b);
            n_checks++;
            if (na > 1 || ((mi_a | ai_a | bi_a | ii_a | oi_a | ri_a) && na != 1) ||
                nb > 1 || ((mi_b | ai_b | bi_b | ii_b | oi_b | ri_b) && nb != 1)) begin
                n_fail++;
                $display("FAIL bus_onehot t=%0t: drivers a=%0d b=%0d words a=%b b=%b", $time,
                         na, nb, w_a, w_b);
            end
        end
    end

    task automatic test_reset();
        int k = 0;
        step_t s;
        logic [20:0] obs;
        reset = 1'b1; opcode = 4'h1; carry_flag = 1'b0; zero_flag = 1'b0;
        #1;
        n_checks++;
        if (w_a !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected %b", w_a, 21'd0);
        end
        push_fetch(4'h1, 1'b0, 1'b0, 0);
        push(4'h1, 1'b0, 1'b0, 1'b0, 0, ts(2) | IO | MI);
        push(4'h1, 1'b0, 1'b0, 1'b0, 0, ts(3) | RO | AI | DONE);
        @(posedge clk); #1;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            opcode = s.op; carry_flag = s.c; zero_flag = s.z; reset = s.rst;
            #1;
            if (s.sel != 2) begin
                obs = (s.sel == 0) ? w_a : w_b;
                n_checks++;
                if (obs !== s.exp) begin
                    n_fail++;
                    $display("FAIL lda step %0d: got %b expected %b", k, obs, s.exp);
                end
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int k = 0;
        step_t s;
        logic [20:0] obs;
        push_fetch(4'h2, 1'b0, 1'b0, 0);
        push(4'h2, 1'b0, 1'b0, 1'b0, 0, ts(2) | IO | MI);
        push(4'h2, 1'b0, 1'b0, 1'b0, 0, ts(3) | RO | BI);
        push(4'h2, 1'b0, 1'b0, 1'b0, 0, ts(4) | EO | AI | FI | DONE);
        push_fetch(4'h3, 1'b0, 1'b0, 0);
        push(4'h3, 1'b0, 1'b0, 1'b0, 0, ts(2) | IO | MI);
        push(4'h3, 1'b0, 1'b0, 1'b0, 0, ts(3) | RO | BI);
        push(4'h3, 1'b0, 1'b0, 1'b0, 0, ts(4) | EO | AI | FI | SU | DONE);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            opcode = s.op; carry_flag = s.c; zero_flag = s.z; reset = s.rst;
            #1;
            if (s.sel != 2) begin
                obs = (s.sel == 0) ? w_a : w_b;
                n_checks++;
                if (obs !== s.exp) begin
                    n_fail++;
                    $display("FAIL add_sub step %0d: got %b expected %b", k, obs, s.exp);
                end
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jumps();
        int k = 0;
        step_t s;
        logic [20:0] obs;
        // Flags toggle opposite to their T2 value during fetch to show only T2 matters.
        push_fetch(4'h7, 1'b1, 1'b1, 0);
        push(4'h7, 1'b0, 1'b1, 1'b0, 0, ts(2) | IO | DONE);
        push_fetch(4'h7, 1'b0, 1'b0, 0);
        push(4'h7, 1'b1, 1'b0, 1'b0, 0, ts(2) | IO | PCL | DONE);
        push_fetch(4'h8, 1'b1, 1'b1, 0);
        push(4'h8, 1'b1, 1'b0, 1'b0, 0, ts(2) | IO | DONE);
        push_fetch(4'h8, 1'b0, 1'b0, 0);
        push(4'h8, 1'b0, 1'b1, 1'b0, 0, ts(2) | IO | PCL | DONE);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            opcode = s.op; carry_flag = s.c; zero_flag = s.z; reset = s.rst;
            #1;
            if (s.sel != 2) begin
                obs = (s.sel == 0) ? w_a : w_b;
                n_checks++;
                if (obs !== s.exp) begin
                    n_fail++;
                    $display("FAIL jumps step %0d: got %b expected %b", k, obs, s.exp);
                end
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ext_ops();
        int k = 0;
        step_t s;
        logic [20:0] obs;
        push_fetch(4'h4, 1'b0, 1'b0, 0);
        push(4'h4, 1'b0, 1'b0, 1'b0, 0, ts(2) | IO | MI);
        push(4'h4, 1'b0, 1'b0, 1'b0, 0, ts(3) | AO | RI | DONE);
        push_fetch(4'h5, 1'b0, 1'b0, 0);
        push(4'h5, 1'b0, 1'b0, 1'b0, 0, ts(2) | IO | AI | DONE);
        push_fetch(4'h6, 1'b0, 1'b0, 0);
        push(4'h6, 1'b0, 1'b0, 1'b0, 0, ts(2) | IO | PCL | DONE);
        push_fetch(4'he, 1'b0, 1'b0, 0);
        push(4'he, 1'b0, 1'b0, 1'b0, 0, ts(2) | AO | OI | DONE);
        push_fetch(4'ha, 1'b0, 1'b0, 0);
        push(4'ha, 1'b0, 1'b0, 1'b0, 0, ts(2) | DONE);
        push_fetch(4'h0, 1'b0, 1'b0, 0);
        push(4'h0, 1'b0, 1'b0, 1'b0, 0, ts(2) | DONE);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            opcode = s.op; carry_flag = s.c; zero_flag = s.z; reset = s.rst;
            #1;
            if (s.sel != 2) begin
                obs = (s.sel == 0) ? w_a : w_b;
                n_checks++;
                if (obs !== s.exp) begin
                    n_fail++;
                    $display("FAIL ext_ops step %0d: got %b expected %b", k, obs, s.exp);
                end
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ext_off();
        int k = 0;
        step_t s;
        logic [20:0] obs;
        logic [3:0] ops [6] = '{4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'ha};
        push(4'h0, 1'b0, 1'b0, 1'b1, 2, 21'd0);
        foreach (ops[i]) begin
            push_fetch(ops[i], 1'b1, 1'b1, 1);
            push(ops[i], 1'b1, 1'b1, 1'b0, 1, ts(2) | DONE);
        end
        while (sb.size() > 0) begin
            s = sb.pop_front();
            opcode = s.op; carry_flag = s.c; zero_flag = s.z; reset = s.rst;
            #1;
            if (s.sel != 2) begin
                obs = (s.sel == 0) ? w_a : w_b;
                n_checks++;
                if (obs !== s.exp) begin
                    n_fail++;
                    $display("FAIL ext_off step %0d: got %b expected %b", k, obs, s.exp);
                end
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_hlt();
        int k = 0;
        step_t s;
        logic [20:0] obs;
        push(4'h0, 1'b0, 1'b0, 1'b1, 2, 21'd0);
        push_fetch(4'hf, 1'b0, 1'b0, 0);
        push(4'hf, 1'b0, 1'b0, 1'b0, 0, ts(2) | HLT | DONE);
        for (int i = 0; i < 22; i++) begin
            push(4'(i), 1'(i), 1'(i >> 1), 1'b0, 0, ts(0) | HLTD | HLT);
        end
        push(4'h1, 1'b0, 1'b0, 1'b1, 0, ts(0) | HLTD);
        push_fetch(4'h0, 1'b0, 1'b0, 0);
        push(4'h0, 1'b0, 1'b0, 1'b0, 0, ts(2) | DONE);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            opcode = s.op; carry_flag = s.c; zero_flag = s.z; reset = s.rst;
            #1;
            if (s.sel != 2) begin
                obs = (s.sel == 0) ? w_a : w_b;
                n_checks++;
                if (obs !== s.exp) begin
                    n_fail++;
                    $display("FAIL hlt step %0d: got %b expected %b", k, obs, s.exp);
                end
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        step_t s;
        logic [20:0] obs;
        push_fetch(4'h2, 1'b0, 1'b0, 0);
        push(4'h2, 1'b0, 1'b0, 1'b0, 0, ts(2) | IO | MI);
        push(4'h2, 1'b0, 1'b0, 1'b1, 0, ts(3));
        push_fetch(4'h0, 1'b0, 1'b0, 0);
        push(4'h0, 1'b0, 1'b0, 1'b0, 0, ts(2) | DONE);
        push_fetch(4'h2, 1'b0, 1'b0, 0);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            opcode = s.op; carry_flag = s.c; zero_flag = s.z; reset = s.rst;
            #1;
            if (s.sel != 2) begin
                obs = (s.sel == 0) ? w_a : w_b;
                n_checks++;
                if (obs !== s.exp) begin
                    n_fail++;
                    $display("FAIL reset_mid step %0d: got %b expected %b", k, obs, s.exp);
                end
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1; opcode = 4'h0; carry_flag = 1'b0; zero_flag = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        running = 1'b1;
        test_reset();
        test_back_to_back();
        test_jumps();
        test_ext_ops();
        test_ext_off();
        test_hlt();
        test_reset_mid();
        running = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sap1_control_sequencer.md
Name: sap1_control_sequencer

Overview:
- Microcode sequencer for the SAP-1 datapath.
- Steps a T-state counter, decodes the 4-bit opcode from the instruction register, and drives the control word for PC, MAR, RAM, IR, A, B, ALU, flags and output register.
- Its pc_inc and pc_load outputs drive the program counter's count enable and set_en; the jump target comes from the IR operand via the bus.
- Instructions are variable length (3–5 cycles); a halt latch stops sequencing until reset.

Parameters:
EXT_ISA, 1, 1 = decode STA/LDI/JMP/JC/JZ; 0 = those opcodes decode as NOP (classic SAP-1 set only)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high; clears T-state and halt latch
opcode  in  4  IR high nibble; valid from T2 onward
carry_flag  in  1  registered carry from flags register
zero_flag  in  1  registered zero from flags register
t_state  out  3  current T-state index 0..4 (debug)
instr_done  out  1  high in the final T-state of each instruction
halted  out  1  halt latch state
hlt  out  1  halt request (clock-stop indication)
mi  out  1  MAR load
ri  out  1  RAM write
ro  out  1  RAM to bus
ii  out  1  IR load
io  out  1  IR operand to bus
ai  out  1  A load
ao  out  1  A to bus
eo  out  1  ALU sum to bus
su  out  1  ALU subtract
fi  out  1  flags load
bi  out  1  B load
oi  out  1  output register load
pc_inc  out  1  PC count enable
co  out  1  PC to bus
pc_load  out  1  PC set_en (jump)

Behaviour:
- State: t_state register, 3 bits, range 0..4; halt_q register. Reset (sync): t_state=0, halt_q=0.
- While reset is high, every control output, instr_done and hlt is forced to 0 combinationally. t_state reads 0 and halted reads 0 after the reset edge.
- Control outputs are combinational decodes of (t_state, opcode, flags, halt_q). No registered latency: a signal asserted in T-state n acts on the rising edge that ends T-state n.
- Fetch, common to all opcodes:
  - T0: co, mi.
  - T1: ro, ii, pc_inc.
- Execute (opcode sampled in T2 and later; the last listed step asserts instr_done, then t_state returns to 0 on the next edge):
  - 0000 NOP: T2 no signals.
  - 0001 LDA: T2 io,mi; T3 ro,ai.
  - 0010 ADD: T2 io,mi; T3 ro,bi; T4 eo,ai,fi.
  - 0011 SUB: as ADD, with su also asserted in T4.
  - 0100 STA: T2 io,mi; T3 ao,ri.
  - 0101 LDI: T2 io,ai.
  - 0110 JMP: T2 io,pc_load.
  - 0111 JC: T2 io, plus pc_load only if carry_flag=1.
  - 1000 JZ: T2 io, plus pc_load only if zero_flag=1.
  - 1110 OUT: T2 ao,oi.
  - 1111 HLT: T2 hlt; halt_q set on that edge.
  - All other opcodes, and 0100–1000 when EXT_ISA=0: NOP.
- Otherwise t_state increments by 1 per cycle. t_state never exceeds 4. An illegal value (5–7) returns to 0 on the next edge with all outputs 0.
- Halted (halt_q=1):
  - t_state holds at 0.
  - All control outputs 0 except hlt=1; halted=1; instr_done=0.
  - Only reset clears it.
- Flag sampling for JC/JZ happens in T2 of the jump only; flag changes in other T-states have no effect.
- Bus drivers: at most one of co, ro, io, ao, eo is high in any cycle. mi/ai/bi/ii/oi/ri never assert without exactly one bus driver.
- Reset mid-instruction: the next cycle is T0 fetch, and no partial-instruction signal asserts after the reset edge.

Test Plan:
- Reset then release with opcode=0001: cycles show T0 {co,mi}, T1 {ro,ii,pc_inc}, T2 {io,mi}, T3 {ro,ai, instr_done}, then t_state=0.
- ADD then SUB back-to-back: ADD T4 has eo,ai,fi with su=0; SUB T4 has su=1; each instruction takes exactly 5 cycles and instr_done pulses once per instruction.
- JC with carry_flag=0 then 1, and JZ with zero_flag=0 then 1:
  - pc_load=0 when the flag is 0 and 1 when it is 1, both in T2.
  - io=1 in T2 in all four cases.
  - Each instruction is 3 cycles.
- HLT (1111): hlt=1 in T2; from the next cycle halted=1 and t_state=0 for 20+ cycles with all other outputs 0; reset clears it and the next cycle is a T0 fetch.
- EXT_ISA=0 with opcodes 0100–1000 and 1010: each behaves as a 3-cycle NOP with no ri/pc_load/ai.
- Assert reset in T3 of ADD: outputs are 0 during reset, bi/eo/fi never assert afterward, and the next cycle is T0 {co,mi}. Across all scenarios, the bus-driver one-hot check passes every cycle.
